fetch_requester: RTL and testbench

FETCH_REQUESTER -- requirements
Module: fetch_requester

---
 rtl/fetch_requester.sv | 172 +++++++++++++++++
 tb/tb_fetch_requester.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_requester.sv
`default_nettype none
// ============================================================================
// Module   : fetch_requester
// Purpose  : Single-outstanding instruction fetcher feeding a small decode FIFO.
//            Optional macro FETCH_ALIGN_CHECK_EN aligns and flags bad redirects.
// Revision : 1.0
// ============================================================================
module fetch_requester #(
  parameter logic [31:0] INITIAL_ADDRES = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] ins_address_o,
  output logic        get_instruction_o,
  input  logic [31:0] read_ins_i,
  input  logic        instruction_completed_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_address_i,
  output logic        ins_valid_o,
  output logic [31:0] ins_o,
  output logic [31:0] ins_pc_o,
  input  logic        decode_ready_i,
  output logic        misaligned_o
);

  localparam int unsigned        c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int unsigned        c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_next;
  logic [31:0]        r_req_addr;
  logic [31:0]        w_redirect_pc;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_next;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [31:0]        r_ins_mem [FIFO_DEPTH];
  logic [31:0]        r_pc_mem  [FIFO_DEPTH];
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_full = (r_count == c_depth);
  // A redirect flushes the buffer, so it overrides any pop or push on that edge.
  assign w_pop  = ins_valid_o && decode_ready_i && !redirect_i;
  assign w_push = (r_state == S_REQUEST) && instruction_completed_i &&
                  !redirect_i && !w_full;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misaligned;

  assign w_redirect_pc = {redirect_address_i[31:2], 2'b00};
  assign misaligned_o  = r_misaligned;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_misaligned <= 1'b0;
    end else if (redirect_i && (redirect_address_i[1:0] != 2'b00)) begin
      r_misaligned <= 1'b1;
    end
  end
`else
  assign w_redirect_pc = redirect_address_i;
  assign misaligned_o  = 1'b0;
`endif

  always_comb begin
    w_count_next = r_count;
    if (redirect_i) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + c_one;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_one;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      S_IDLE: begin
        if (redirect_i || (r_count < c_depth)) begin
          w_state_next = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (instruction_completed_i) begin
          if (redirect_i) begin
            w_state_next = S_IDLE;
          end else begin
            if (w_push) begin
              w_pc_next = r_pc + 32'd4;
            end
            w_state_next = (w_count_next < c_depth) ? S_REQUEST : S_IDLE;
          end
        end else if (redirect_i) begin
          // Memory cannot cancel; wait out the old access and drop its word.
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (instruction_completed_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (redirect_i) begin
      w_pc_next = w_redirect_pc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_pc       <= INITIAL_ADDRES;
      r_req_addr <= INITIAL_ADDRES;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      // The presented address freezes while draining the abandoned access.
      if (w_state_next != S_DRAIN) begin
        r_req_addr <= w_pc_next;
      end
      if (redirect_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_ins_mem[r_wr_ptr] <= read_ins_i;
      r_pc_mem[r_wr_ptr]  <= r_pc;
    end
  end

  assign get_instruction_o = (r_state == S_REQUEST) || (r_state == S_DRAIN);
  assign ins_address_o     = r_req_addr;
  assign ins_valid_o       = (r_count != '0);
  assign ins_o             = r_ins_mem[r_rd_ptr];
  assign ins_pc_o          = r_pc_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fetch_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_requester
// Purpose  : Directed self-checking bench for fetch_requester with a
//            behavioural instruction memory of configurable latency.
// Revision : 1.0
// ============================================================================
module tb_fetch_requester;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ins_address_o;
  logic        get_instruction_o;
  logic [31:0] read_ins_i;
  logic        instruction_completed_i;
  logic        redirect_i;
  logic [31:0] redirect_address_i;
  logic        ins_valid_o;
  logic [31:0] ins_o;
  logic [31:0] ins_pc_o;
  logic        decode_ready_i;
  logic        misaligned_o;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 0;
  int          mem_cnt = 0;
  int          n_comp = 0;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];

  fetch_requester dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .ins_address_o          (ins_address_o),
    .get_instruction_o      (get_instruction_o),
    .read_ins_i             (read_ins_i),
    .instruction_completed_i(instruction_completed_i),
    .redirect_i             (redirect_i),
    .redirect_address_i     (redirect_address_i),
    .ins_valid_o            (ins_valid_o),
    .ins_o                  (ins_o),
    .ins_pc_o               (ins_pc_o),
    .decode_ready_i         (decode_ready_i),
    .misaligned_o           (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock: log pops/completions on this edge, then model the memory.
  task automatic tick();
    if (!rst_i && !redirect_i && ins_valid_o && decode_ready_i) begin
      pop_pc.push_back(ins_pc_o);
      pop_ins.push_back(ins_o);
    end
    if (!rst_i && get_instruction_o && instruction_completed_i) n_comp++;
    if (get_instruction_o && instruction_completed_i) mem_cnt = 0;
    else if (get_instruction_o) mem_cnt++;
    @(posedge clk_i);
    #1;
    instruction_completed_i = get_instruction_o && (mem_cnt >= mem_lat);
    read_ins_i = get_instruction_o ? word_of(ins_address_o) : 32'hDEAD_BEEF;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    redirect_i = 1'b0;
    tick();
    tick();
    mem_cnt = 0;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    redirect_i = 1'b0;
    redirect_address_i = 32'h0;
    decode_ready_i = 1'b1;
    instruction_completed_i = 1'b0;
    read_ins_i = 32'h0;
    mem_lat = 0;
    tick();
    tick();
    checks++; if (get_instruction_o !== 1'b0) begin errors++; $display("FAIL reset_get got=%b exp=0", get_instruction_o); end
    checks++; if (ins_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ins_valid_o); end
    checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%b exp=0", misaligned_o); end
    mem_cnt = 0;
    rst_i = 1'b0;
    tick();
    checks++; if (get_instruction_o !== 1'b1) begin errors++; $display("FAIL first_get got=%b exp=1", get_instruction_o); end
    checks++; if (ins_address_o !== 32'h8000_0000) begin errors++; $display("FAIL first_addr got=%h exp=80000000", ins_address_o); end
    checks++; if (ins_valid_o !== 1'b0) begin errors++; $display("FAIL first_valid got=%b exp=0", ins_valid_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ins_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, ins_valid_o); end
      checks++; if (ins_pc_o !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, ins_pc_o, exp_pc); end
      checks++; if (ins_o !== word_of(exp_pc)) begin errors++; $display("FAIL seq_ins[%0d] got=%h exp=%h", i, ins_o, word_of(exp_pc)); end
      checks++; if (ins_address_o !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, ins_address_o, exp_pc + 32'd4); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall();
    logic [31:0] head;
    int          comp0;
    int          n_buf;
    head = 32'h8000_000C;
    pop_pc.delete();
    pop_ins.delete();
    decode_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (get_instruction_o !== 1'b0) begin errors++; $display("FAIL stall_get got=%b exp=0", get_instruction_o); end
    checks++; if (ins_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", ins_valid_o); end
    checks++; if (ins_pc_o !== head) begin errors++; $display("FAIL stall_head got=%h exp=%h", ins_pc_o, head); end
    decode_ready_i = 1'b1;
    comp0 = n_comp;
    n_buf = 0;
    for (int k = 0; (k < 40) && (pop_pc.size() < 6); k++) begin
      if (ins_valid_o && (n_comp == comp0)) n_buf++;
      tick();
    end
    checks++; if (pop_pc.size() < 6) begin errors++; $display("FAIL stall_timeout got=%0d exp=6 pops", pop_pc.size()); end
    checks++; if (n_buf != 2) begin errors++; $display("FAIL stall_buffered got=%0d exp=2", n_buf); end
    for (int i = 0; (i < 6) && (i < pop_pc.size()); i++) begin
      checks++;
      if (pop_pc[i] !== head + 32'(4 * i) || pop_ins[i] !== word_of(head + 32'(4 * i))) begin
        errors++;
        $display("FAIL stall_seq[%0d] got=%h/%h exp=%h/%h", i, pop_pc[i], pop_ins[i],
                 head + 32'(4 * i), word_of(head + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_redirect_drain();
    bit got;
    mem_lat = 3;
    decode_ready_i = 1'b1;
    apply_reset();
    redirect_address_i = 32'h8000_0100;
    redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_instruction_o !== 1'b1 || ins_address_o !== 32'h8000_0000) begin
        errors++;
        $display("FAIL drain_hold[%0d] got=%b/%h exp=1/80000000", k, get_instruction_o, ins_address_o);
      end
      if (k < 2) tick();
    end
    tick();
    checks++; if (ins_valid_o !== 1'b0) begin errors++; $display("FAIL drain_discard got=%b exp=0", ins_valid_o); end
    got = 1'b0;
    for (int k = 0; (k < 20) && !got; k++) begin
      tick();
      if (ins_valid_o) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL drain_timeout got=no_valid exp=valid");
    end else begin
      checks++; if (ins_pc_o !== 32'h8000_0100) begin errors++; $display("FAIL drain_pc got=%h exp=80000100", ins_pc_o); end
      checks++; if (ins_o !== word_of(32'h8000_0100)) begin errors++; $display("FAIL drain_ins got=%h exp=%h", ins_o, word_of(32'h8000_0100)); end
    end
    mem_lat = 0;
  endtask

  task automatic test_redirect_same_edge();
    mem_lat = 0;
    decode_ready_i = 1'b0;
    apply_reset();
    tick();
    checks++; if (ins_valid_o !== 1'b1 || ins_pc_o !== 32'h8000_0000) begin errors++; $display("FAIL same_pre got=%b/%h exp=1/80000000", ins_valid_o, ins_pc_o); end
    redirect_address_i = 32'h8000_0200;
    redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    checks++; if (ins_valid_o !== 1'b0) begin errors++; $display("FAIL same_flush got=%b exp=0", ins_valid_o); end
    checks++; if (get_instruction_o !== 1'b0) begin errors++; $display("FAIL same_idle got=%b exp=0", get_instruction_o); end
    tick();
    checks++; if (get_instruction_o !== 1'b1 || ins_address_o !== 32'h8000_0200) begin errors++; $display("FAIL same_refetch got=%b/%h exp=1/80000200", get_instruction_o, ins_address_o); end
    tick();
    checks++; if (ins_valid_o !== 1'b1 || ins_pc_o !== 32'h8000_0200) begin errors++; $display("FAIL same_head got=%b/%h exp=1/80000200", ins_valid_o, ins_pc_o); end
    checks++; if (ins_o !== word_of(32'h8000_0200)) begin errors++; $display("FAIL same_ins got=%h exp=%h", ins_o, word_of(32'h8000_0200)); end
  endtask

  task automatic test_misaligned();
    logic [31:0] exp_addr;
    logic        exp_mis;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_addr = 32'h8000_0100;
    exp_mis  = 1'b1;
`else
    exp_addr = 32'h8000_0102;
    exp_mis  = 1'b0;
`endif
    mem_lat = 0;
    decode_ready_i = 1'b1;
    apply_reset();
    redirect_address_i = 32'h8000_0102;
    redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    checks++; if (misaligned_o !== exp_mis) begin errors++; $display("FAIL mis_flag got=%b exp=%b", misaligned_o, exp_mis); end
    tick();
    checks++; if (get_instruction_o !== 1'b1 || ins_address_o !== exp_addr) begin errors++; $display("FAIL mis_addr got=%b/%h exp=1/%h", get_instruction_o, ins_address_o, exp_addr); end
    tick();
    checks++; if (ins_valid_o !== 1'b1 || ins_pc_o !== exp_addr) begin errors++; $display("FAIL mis_head got=%b/%h exp=1/%h", ins_valid_o, ins_pc_o, exp_addr); end
    redirect_address_i = 32'h8000_0200;
    redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    checks++; if (misaligned_o !== exp_mis) begin errors++; $display("FAIL mis_sticky got=%b exp=%b", misaligned_o, exp_mis); end
  endtask

  task automatic test_reset_mid_request();
    mem_lat = 0;
    decode_ready_i = 1'b0;
    apply_reset();
    checks++; if (instruction_completed_i !== 1'b1) begin errors++; $display("FAIL rstmid_setup got=%b exp=1", instruction_completed_i); end
    rst_i = 1'b1;
    tick();
    checks++; if (ins_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", ins_valid_o); end
    checks++; if (get_instruction_o !== 1'b0) begin errors++; $display("FAIL rstmid_get got=%b exp=0", get_instruction_o); end
    checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL rstmid_mis got=%b exp=0", misaligned_o); end
    mem_cnt = 0;
    rst_i = 1'b0;
    tick();
    checks++; if (get_instruction_o !== 1'b1 || ins_address_o !== 32'h8000_0000) begin errors++; $display("FAIL rstmid_addr got=%b/%h exp=1/80000000", get_instruction_o, ins_address_o); end
    tick();
    checks++; if (ins_valid_o !== 1'b1 || ins_pc_o !== 32'h8000_0000) begin errors++; $display("FAIL rstmid_head got=%b/%h exp=1/80000000", ins_valid_o, ins_pc_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_redirect_same_edge();
    test_misaligned();
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
